demux_1to8: RTL and testbench

// - Registered 1-to-8 demultiplexer: routes the single data input a to the output lane selected by s.
// - Drives all other lanes to 0.
// - Generic steering/decode leaf, e.g. for strobe fan-out or per-channel enables.
// - Output is registered on one clock; synchronous active-low reset.

---
 rtl/demux_1to8.sv | 49 ++++
 tb/tb_demux_1to8.sv | 119 +++++++++++
 2 files changed

// File: rtl/demux_1to8.sv
// rtl/demux_1to8.sv - registered 1-to-8 demultiplexer with parameterised lane width
//
// Purpose:
//   Steers the data input a onto the output lane chosen by s and drives the
//   other seven lanes to zero. The result is registered, so f changes only on
//   the rising edge of clk. There is no combinational path from a or s to f.
//
// Ports:
//   clk    in   1     single clock, rising edge
//   rst_n  in   1     synchronous active-low reset; clears every lane
//   a      in   DW    data to steer
//   s      in   3     lane select, 0..7
//   f      out  8*DW  output lanes; lane k is f[k*DW +: DW]

module demux_1to8 #(
  parameter int unsigned DW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   a,
  input  logic [2:0]      s,
  output logic [8*DW-1:0] f
);

  logic [8*DW-1:0] f_d;
  logic [8*DW-1:0] f_q;

  // Each lane compares its own index against s. This avoids a variable
  // part-select and gives one small decode per lane.
  always_comb begin
    f_d = '0;
    for (int k = 0; k < 8; k++) begin
      if (s == 3'(k)) begin
        f_d[k*DW +: DW] = a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_q <= '0;
    end else begin
      f_q <= f_d;
    end
  end

  assign f = f_q;

endmodule

// File: tb/tb_demux_1to8.sv
// tb/tb_demux_1to8.sv - randomized self-checking bench for demux_1to8

module tb_demux_1to8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a;
  logic [3:0]  a4;
  logic [2:0]  s;
  logic [7:0]  f;
  logic [31:0] f4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux_1to8 #(.DW(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .s     (s),
    .f     (f)
  );

  demux_1to8 #(.DW(4)) u_dut_w4 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a4),
    .s     (s),
    .f     (f4)
  );

  // Reference: after an edge with reset low, every lane is zero. Otherwise the
  // data value is shifted up to lane s, which is a shift of s*dw bits.
  function automatic logic [31:0] model(logic rst, logic [3:0] d, logic [2:0] sel, int dw);
    if (!rst) return 32'h0;
    return 32'(d) << (int'(sel) * dw);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Computes the expected values from the inputs that are present before the
  // edge, then samples both DUTs 1 time unit after the edge.
  task automatic tick(string tag);
    logic [31:0] e1;
    logic [31:0] e4;
    e1 = model(rst_n, {3'b000, a}, s, 1);
    e4 = model(rst_n, a4, s, 4);
    @(posedge clk);
    #1;
    check(tag, {24'h0, f}, e1);
    check({tag, "/w4"}, f4, e4);
  endtask

  initial begin
    // Reset is held for two edges while the inputs would otherwise select a lane.
    rst_n = 1'b0; a = 1'b1; s = 3'b101; a4 = 4'hf;
    tick("reset0");
    check("reset0_const", {24'h0, f}, 32'h0);
    tick("reset1");

    // With a=0, the output is zero.
    rst_n = 1'b1; a = 1'b0; s = 3'b000; a4 = 4'h0;
    tick("a0_s0");
    check("a0_s0_const", {24'h0, f}, 32'h0);

    // Sweep s with a=1. The expected results are one-hot values.
    a = 1'b1; a4 = 4'h9;
    for (int i = 0; i < 8; i++) begin
      s = 3'(i);
      tick("sweep");
      check("sweep_onehot", {24'h0, f}, 32'h1 << i);
    end

    // Latency: a change to s between edges must not appear on f before the next edge.
    s = 3'b010;
    tick("lat_pre");
    s = 3'b110;
    @(negedge clk);
    check("lat_hold", {24'h0, f}, 32'h04);
    tick("lat_post");
    check("lat_post_const", {24'h0, f}, 32'h40);

    // Reset asserted in the middle of a stream of data.
    s = 3'b111; a4 = 4'h5;
    tick("mid_pre");
    rst_n = 1'b0;
    tick("mid_rst");
    rst_n = 1'b1;
    tick("mid_rel");
    check("mid_rel_const", {24'h0, f}, 32'h80);

    // Toggle a with s fixed.
    s = 3'b011;
    a = 1'b1; tick("tog1");
    a = 1'b0; tick("tog0");
    a = 1'b1; tick("tog1b");

    // Random inputs. Reset is asserted on some cycles.
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 9) != 0);
      a     = 1'($urandom);
      s     = 3'($urandom);
      a4    = 4'($urandom);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
